// File: rtl/dac_sched.sv
// dac_sched: two-requester update scheduler for the dual-channel 12-bit SPI DAC.
//
// Holds one sample per channel (A, B), arbitrates between pending samples, builds
// the 32-bit DAC command frame and sequences the 32-bit spi core through its
// en / data2trans / ss interface, one frame at a time.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset (shared with the spi core)
//   a_valid_i    channel A sample offered
//   a_data_i     channel A 12-bit sample
//   a_ready_o    channel A holding register empty
//   b_valid_i    channel B sample offered
//   b_data_i     channel B 12-bit sample
//   b_ready_o    channel B holding register empty
//   spi_en_o     two-cycle start strobe to the spi core
//   spi_data_o   frame to the spi core, held from grant to next grant
//   spi_ss_i     spi core slave select: low while a frame is in flight
//   busy_o       high whenever the sequencer is not idle
//   last_ch_o    channel of the most recent grant (0 = A, 1 = B)
//   err_o        one-cycle pulse when spi_ss never falls after the strobe
//
// Build option: define DAC_SCHED_FIXED_PRIO_EN for fixed priority (A always
// wins a tie); otherwise ties are broken round-robin.

module dac_sched #(
  parameter logic [3:0]  ADDR_A      = 4'b0000,
  parameter logic [3:0]  ADDR_B      = 4'b0001,
  parameter logic [3:0]  COMMAND     = 4'b0011,
  parameter int unsigned ARM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid_i,
  input  logic [11:0] a_data_i,
  output logic        a_ready_o,
  input  logic        b_valid_i,
  input  logic [11:0] b_data_i,
  output logic        b_ready_o,
  output logic        spi_en_o,
  output logic [31:0] spi_data_o,
  input  logic        spi_ss_i,
  output logic        busy_o,
  output logic        last_ch_o,
  output logic        err_o
);

  localparam int unsigned CntW = $clog2(ARM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StEn1,
    StEn2,
    StArm,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic            pend_a_q, pend_a_d;
  logic            pend_b_q, pend_b_d;
  logic [11:0]     data_a_q, data_a_d;
  logic [11:0]     data_b_q, data_b_d;
  logic [31:0]     spi_data_q, spi_data_d;
  logic            last_ch_q, last_ch_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            grant;
  logic            grant_b;
  logic [CntW-1:0] cnt_inc;

  assign grant = (state_q == StIdle) && (pend_a_q || pend_b_q);

`ifdef DAC_SCHED_FIXED_PRIO_EN
  // A always wins a tie; B only goes when A has nothing pending.
  assign grant_b = pend_b_q && !pend_a_q;
`else
  // On a tie the channel opposite the last grant wins.
  assign grant_b = pend_b_q && (!pend_a_q || !last_ch_q);
`endif

  assign cnt_inc = cnt_q + CntW'(1);

  // FSM next-state and timeout counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant) state_d = StEn1;
      end
      StEn1: begin
        state_d = StEn2;
      end
      StEn2: begin
        state_d = StArm;
        cnt_d   = '0;
      end
      StArm: begin
        if (!spi_ss_i) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(ARM_TIMEOUT)) begin
            // Core never started: drop the frame and flag it.
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
      StDone: begin
        if (spi_ss_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding registers, frame register and arbitration history.
  // A pending channel has ready low, so accept and grant never coincide.
  always_comb begin
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    spi_data_d = spi_data_q;
    last_ch_d  = last_ch_q;

    if (a_valid_i && !pend_a_q) begin
      pend_a_d = 1'b1;
      data_a_d = a_data_i;
    end
    if (b_valid_i && !pend_b_q) begin
      pend_b_d = 1'b1;
      data_b_d = b_data_i;
    end

    if (grant) begin
      last_ch_d = grant_b;
      if (grant_b) begin
        pend_b_d   = 1'b0;
        spi_data_d = {8'd0, COMMAND, ADDR_B, data_b_q, 4'd0};
      end else begin
        pend_a_d   = 1'b0;
        spi_data_d = {8'd0, COMMAND, ADDR_A, data_a_q, 4'd0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      spi_data_q <= '0;
      last_ch_q  <= 1'b1;  // so A wins the first tie
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      spi_data_q <= spi_data_d;
      last_ch_q  <= last_ch_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign a_ready_o  = !pend_a_q;
  assign b_ready_o  = !pend_b_q;
  assign spi_en_o   = (state_q == StEn1) || (state_q == StEn2);
  assign busy_o     = (state_q != StIdle);
  assign spi_data_o = spi_data_q;
  assign last_ch_o  = last_ch_q;
  assign err_o      = err_q;

endmodule

// File: doc/dac_sched.md
# dac_sched

Two-requester update scheduler for the dual-channel 12-bit SPI DAC. It accepts samples from two independent producers (channel A and channel B) through valid/ready handshakes and holds one sample per channel. It arbitrates between them and assembles the 32-bit DAC command frame. It then sequences the team's 32-bit `spi` core through its `en`/`data2trans`/`ss` interface, one frame at a time. It sits between the waveform generators and the `spi` core, and replaces per-channel ad-hoc sequencing.

## Interface
- `ADDR_A`, 4'b0000, DAC address field used for channel A frames
- `ADDR_B`, 4'b0001, DAC address field used for channel B frames
- `COMMAND`, 4'b0011, DAC command field (write-and-update) placed in every frame
- `ARM_TIMEOUT`, 15, max cycles to wait for `spi_ss` to fall after the enable pulse
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `a_valid`  in  1  channel A sample offered
- `a_data`  in  12  channel A sample
- `a_ready`  out  1  channel A holding register empty
- `b_valid`  in  1  channel B sample offered
- `b_data`  in  12  channel B sample
- `b_ready`  out  1  channel B holding register empty
- `spi_en`  out  1  start strobe to `spi` core
- `spi_data`  out  32  frame to `spi` core (`data2trans`)
- `spi_ss`  in  1  `spi` core slave select: low while a frame is in flight, high when idle
- `busy`  out  1  high in any state other than IDLE
- `last_ch`  out  1  channel of the most recently granted frame (0=A, 1=B)
- `err`  out  1  one-cycle pulse on ARM timeout

## Operation
- Holding registers: `pend_a`/`pend_b` flags plus a 12-bit data register per channel. `a_ready = !pend_a`, `b_ready = !pend_b`.
- On an edge with `x_valid & x_ready`, capture `x_data` and set `pend_x`.
- A pending flag clears only on the grant edge. A channel is never accepted and granted on the same edge.
- Frame format: `{8'd0, COMMAND, ADDR_x, data_x, 4'd0}`. It is registered into `spi_data` on the grant edge and held stable until the next grant.
- Arbitration, applied in IDLE when any flag is pending:
  - only one channel pending: that channel wins
  - both pending: round-robin, the winner is the channel opposite `last_ch`
  - `last_ch` updates on the grant edge
- FSM states:
  - IDLE: on any pending flag, grant and go to EN1; otherwise stay.
  - EN1: `spi_en`=1; go to EN2.
  - EN2: `spi_en`=1; go to ARM and clear the timeout counter.
  - ARM: if `spi_ss`==0, go to DONE. Otherwise increment the counter; when the counter reaches `ARM_TIMEOUT`, pulse `err` and go to IDLE (the frame is dropped).
  - DONE: when `spi_ss`==1, go to IDLE. There is no timeout in this state.
- The next grant is possible on the first edge in IDLE, so there are no idle cycles between back-to-back frames beyond the single IDLE cycle.
- Async reset, mid-frame included:
  - state goes to IDLE and all pending flags clear; held samples are lost
  - `spi_en`=0, `spi_data`=0, `last_ch`=1 (so A wins first), `err`=0, `busy`=0
  - the `spi` core is reset by the same `rst`

## Timing
- `spi_en`, `busy` and `err` are decoded from registered state and counter only. They have no combinational path from inputs.
- Latency, sample accepted at edge N with the FSM in IDLE and no competitor:
  - grant at edge N+1
  - `spi_en` high during cycles N+1..N+2, exactly two cycles
  - ARM from edge N+3
- `x_ready` rises the cycle after the grant edge. A new sample can therefore be loaded while the previous frame is still in flight (double buffering).
- Both channels streaming continuously: frames strictly alternate A, B, A, B.
- `err` lasts exactly one cycle: the cycle following the edge that leaves ARM on timeout.

## Configuration
- `DAC_SCHED_FIXED_PRIO_EN` defined: fixed priority. A always wins when both are pending, so B can starve under continuous A traffic. `last_ch` still reports the granted channel.
- Not defined: round-robin as described in Operation (the default).

## Test plan
- Single A sample 12'hABC, with `spi_ss` model falling 2 cycles after `spi_en` and rising 32 cycles later:
  - `spi_data` = 32'h0030ABC0
  - `spi_en` high for exactly 2 cycles
  - `busy` low again one cycle after `spi_ss` rises
- A=12'h111 and B=12'h222 offered on the same edge after reset:
  - A frame 32'h00301110 is sent first, then B frame 32'h00312220
  - `last_ch` reads 0 then 1
- A held valid continuously, B offered once:
  - B is granted at the next arbitration after the current A frame; A is not granted twice in a row
  - with `DAC_SCHED_FIXED_PRIO_EN` defined, B waits until A stops
- `spi_ss` held high after the enable pulse:
  - `err` pulses once, 15 cycles into ARM
  - FSM returns to IDLE
  - a following sample is sent normally
- Double buffering: a second A sample is offered while a frame is in flight:
  - it is accepted the cycle after the grant (`a_ready`=1)
  - it is then held with `a_ready`=0 until the next grant
- `rst` asserted during DONE with both channels pending:
  - `spi_en`, `spi_data` and `busy` go to 0 immediately
  - no frame is sent after release until new valid samples arrive
